// File: rtl/ram_arb_ctrl_if.sv
// ram_arb_ctrl_if: requester-side bundle of the two-port SRAM arbiter.
// Carries both ports' request/write qualifiers, addresses and write data,
// plus the combinational grants, read-return pulses, shared read data and
// the init-done flag. The master modport is the requester side; the slave
// modport is the controller side.
interface ram_arb_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 5
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata;
   logic          init_done;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, init_done
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, init_done
   );
endinterface

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: shares one single-port synchronous SRAM between two
// requesters. After reset the whole SRAM is cleared to zero (INIT), then
// at most one access per cycle is granted (RUN), round-robin by default.
// A read accepted in cycle N strobes the SRAM in N+1, the SRAM returns data
// in N+2 and rdata/rvalidN are registered in N+3.
//
// Build option: define RAM_ARB_FIXED_PRIO_EN to make port 0 always win a
// collision (the round-robin pointer is then not built; port 1 may starve).
module ram_arb_ctrl #(
   parameter int AW = 8,
   parameter int DW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_arb_ctrl_if.slave bus,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // The counter is one bit wider than the address so the last address of
   // the sweep is compared before anything can wrap back to zero.
   localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
   localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

   state_t        state_r;
   state_t        state_s;
   logic [AW:0]   cnt_r;
   logic [AW:0]   cnt_s;
   logic          init_done_r;
   logic          init_done_s;

   logic          ram_cs_r;
   logic          ram_cs_s;
   logic          ram_we_r;
   logic          ram_we_s;
   logic [AW-1:0] ram_addr_r;
   logic [AW-1:0] ram_addr_s;
   logic [DW-1:0] ram_din_r;
   logic [DW-1:0] ram_din_s;

   // Port tag pipeline: stage 1 is aligned with the SRAM strobe, stage 2
   // with the SRAM data output.
   logic          p1_vld_r;
   logic          p1_vld_s;
   logic          p1_port_r;
   logic          p1_port_s;
   logic          p2_vld_r;
   logic          p2_port_r;

   logic          rvalid0_r;
   logic          rvalid1_r;
   logic [DW-1:0] rdata_r;

   logic          gnt0_s;
   logic          gnt1_s;
   logic          acc_s;
   logic          sel_we_s;

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Pointer names the port that wins the next collision (0 = port 0).
   logic          ptr_r;
   logic          ptr_s;
`endif

   // Arbitration: grants are combinational from requests, pointer and state.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (state_r == ST_RUN) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         gnt0_s = bus.req0;
         gnt1_s = bus.req1 & ~bus.req0;
`else
         gnt0_s = bus.req0 & (~bus.req1 | ~ptr_r);
         gnt1_s = bus.req1 & (~bus.req0 |  ptr_r);
`endif
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   assign acc_s    = gnt0_s | gnt1_s;
   assign sel_we_s = gnt1_s ? bus.we1 : bus.we0;

   // Next-state logic: clear sweep in INIT, issue of the accepted access in RUN.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      init_done_s = init_done_r;
      ram_cs_s    = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = ram_addr_r;
      ram_din_s   = ram_din_r;
      p1_vld_s    = 1'b0;
      p1_port_s   = p1_port_r;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_s       = ptr_r;
`endif
      case (state_r)
         ST_INIT: begin
            ram_cs_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = cnt_r[AW-1:0];
            ram_din_s  = {DW{1'b0}};
            cnt_s      = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
               state_s     = ST_RUN;
               init_done_s = 1'b1;
            end else begin
               state_s     = ST_INIT;
               init_done_s = 1'b0;
            end
         end
         ST_RUN: begin
            if (acc_s) begin
               ram_cs_s   = 1'b1;
               ram_we_s   = sel_we_s;
               ram_addr_s = gnt1_s ? bus.addr1  : bus.addr0;
               ram_din_s  = gnt1_s ? bus.wdata1 : bus.wdata0;
               p1_vld_s   = ~sel_we_s;
               p1_port_s  = gnt1_s;
`ifndef RAM_ARB_FIXED_PRIO_EN
               // Hand the next collision to the port that was not served.
               ptr_s      = gnt0_s;
`endif
            end else begin
               ram_cs_s   = 1'b0;
               ram_we_s   = 1'b0;
            end
         end
         default: begin
            state_s     = ST_INIT;
            cnt_s       = {(AW+1){1'b0}};
            init_done_s = 1'b0;
         end
      endcase
   end

   // State, SRAM strobes, tag pipeline and read-return registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_INIT;
         cnt_r       <= {(AW+1){1'b0}};
         init_done_r <= 1'b0;
         ram_cs_r    <= 1'b0;
         ram_we_r    <= 1'b0;
         ram_addr_r  <= {AW{1'b0}};
         ram_din_r   <= {DW{1'b0}};
         p1_vld_r    <= 1'b0;
         p1_port_r   <= 1'b0;
         p2_vld_r    <= 1'b0;
         p2_port_r   <= 1'b0;
         rvalid0_r   <= 1'b0;
         rvalid1_r   <= 1'b0;
         rdata_r     <= {DW{1'b0}};
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         init_done_r <= init_done_s;
         ram_cs_r    <= ram_cs_s;
         ram_we_r    <= ram_we_s;
         ram_addr_r  <= ram_addr_s;
         ram_din_r   <= ram_din_s;
         p1_vld_r    <= p1_vld_s;
         p1_port_r   <= p1_port_s;
         p2_vld_r    <= p1_vld_r;
         p2_port_r   <= p1_port_r;
         rvalid0_r   <= p2_vld_r & ~p2_port_r;
         rvalid1_r   <= p2_vld_r &  p2_port_r;
         if (p2_vld_r) begin
            rdata_r <= ram_dout;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= 1'b0;
      end else begin
         ptr_r <= ptr_s;
      end
   end
`endif

   assign bus.gnt0      = gnt0_s;
   assign bus.gnt1      = gnt1_s;
   assign bus.rvalid0   = rvalid0_r;
   assign bus.rvalid1   = rvalid1_r;
   assign bus.rdata     = rdata_r;
   assign bus.init_done = init_done_r;

   assign ram_cs   = ram_cs_r;
   assign ram_we   = ram_we_r;
   assign ram_addr = ram_addr_r;
   assign ram_din  = ram_din_r;

endmodule
